// File: rtl/pdm_to_cic_adapter.sv
// Serializes one NUM_MICS-bit PDM word into NUM_MICS signed +/-1 AXI-Stream beats (mic 0 first),
// with TLAST on the last mic, for a shared CIC decimator.
module pdm_to_cic_adapter #(
  parameter int unsigned NUM_MICS  = 5,
  parameter int unsigned CIC_BYTES = 1,
  parameter int unsigned CIC_BITS  = CIC_BYTES * 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [NUM_MICS-1:0] s_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [CIC_BITS-1:0] m_axis_tdata,
  output logic                m_axis_tlast
);

  localparam int unsigned IDX_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MICS - 1);
  localparam logic [CIC_BITS-1:0] POS_ONE = CIC_BITS'(1);
  localparam logic [CIC_BITS-1:0] NEG_ONE = '1;

  logic [NUM_MICS-1:0] word_q, word_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                valid_n, last_n;
  logic [CIC_BITS-1:0] data_n;
  logic [NUM_MICS-1:0] shifted;
  logic                load;
  logic                in_xfer, out_xfer;

  // Next word may enter when the output stage is idle or its last beat is leaving now.
  assign s_axis_tready = !rst && (!m_axis_tvalid || (m_axis_tready && m_axis_tlast));
  assign in_xfer       = s_axis_tvalid && s_axis_tready;
  assign out_xfer      = m_axis_tvalid && m_axis_tready;

  always_comb begin
    word_n  = word_q;
    idx_n   = idx_q;
    valid_n = m_axis_tvalid;
    data_n  = m_axis_tdata;
    last_n  = m_axis_tlast;
    load    = 1'b0;
    shifted = '0;

    if (in_xfer) begin
      word_n  = s_axis_tdata;
      idx_n   = '0;
      valid_n = 1'b1;
      load    = 1'b1;
    end else if (out_xfer) begin
      if (m_axis_tlast) begin
        valid_n = 1'b0;
        idx_n   = '0;
      end else begin
        idx_n   = idx_q + IDX_W'(1);
        load    = 1'b1;
      end
    end

    // Present the beat for mic idx_n: bit set -> +1, clear -> -1.
    if (load) begin
      shifted = word_n >> idx_n;
      data_n  = shifted[0] ? POS_ONE : NEG_ONE;
      last_n  = (idx_n == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q        <= '0;
      idx_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      word_q        <= word_n;
      idx_q         <= idx_n;
      m_axis_tvalid <= valid_n;
      m_axis_tdata  <= data_n;
      m_axis_tlast  <= last_n;
    end
  end

endmodule

// File: tb/tb_pdm_to_cic_adapter.sv
// Scoreboard bench for pdm_to_cic_adapter: accepted input words push expected beats,
// an independent monitor pops and compares every output transfer.
module tb_pdm_to_cic_adapter;

  localparam int unsigned NUM_MICS = 5;
  localparam int unsigned CIC_BITS = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_tvalid;
  logic                s_tready;
  logic [NUM_MICS-1:0] s_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic [CIC_BITS-1:0] m_tdata;
  logic                m_tlast;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned beats_seen = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;
  logic        stall_prev = 1'b0;
  logic [8:0]  stall_snap = '0;

  pdm_to_cic_adapter #(.NUM_MICS(NUM_MICS), .CIC_BYTES(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side: every accepted word yields five expected beats.
  always @(negedge clk) begin
    if (!rst && s_tvalid && s_tready)
      for (int k = 0; k < NUM_MICS; k++)
        exp_q.push_back({(k == NUM_MICS - 1), (s_tdata[k] ? 8'h01 : 8'hFF)});
  end

  // Monitor: compare each output transfer and AXI hold rules under stall.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_hold", 32'(m_tvalid), 32'd1);
        chk("stall_data_hold", 32'({m_tlast, m_tdata}), 32'(stall_snap));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", {m_tlast, m_tdata}, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", 32'({m_tlast, m_tdata}), 32'(mon_e));
          beats_seen++;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      stall_snap = {m_tlast, m_tdata};
    end
  end

  // Send one word with free-flowing output and check the five beats against hand values.
  task automatic frame_directed(input string name, input logic [4:0] w, input logic [39:0] exp);
    s_tvalid = 1'b1;
    s_tdata  = w;
    m_tready = 1'b1;
    #1;
    chk({name, "_in_ready"}, 32'(s_tready), 32'd1);
    tick();
    s_tvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk({name, "_valid"}, 32'(m_tvalid), 32'd1);
      chk({name, "_data"}, 32'(m_tdata), 32'(exp[8*k +: 8]));
      chk({name, "_last"}, 32'(m_tlast), 32'(k == 4));
      tick();
    end
    chk({name, "_valid_drop"}, 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    logic [4:0] words [4];
    int unsigned cnt;
    int unsigned n_acc;
    int unsigned valid_cycles;
    logic acc;

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;

    // Reset held 4 cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_valid", 32'(m_tvalid), 32'd0);
      chk("rst_last", 32'(m_tlast), 32'd0);
      chk("rst_in_ready", 32'(s_tready), 32'd0);
    end
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(s_tready), 32'd1);
    chk("post_rst_data", 32'(m_tdata), 32'd0);
    chk("post_rst_valid", 32'(m_tvalid), 32'd0);

    // Single word 00101 -> 01,FF,01,FF,FF
    frame_directed("single", 5'b00101, 40'hFFFF01FF01);

    // Backpressure mid-frame on beat 2 of 10110
    s_tvalid = 1'b1; s_tdata = 5'b10110; m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    tick();
    tick();
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(m_tvalid), 32'd1);
      chk("bp_data", 32'(m_tdata), 32'h01);
      chk("bp_last", 32'(m_tlast), 32'd0);
      chk("bp_in_ready", 32'(s_tready), 32'd0);
    end
    m_tready = 1'b1;
    tick(); tick(); tick();
    chk("bp_drain_valid", 32'(m_tvalid), 32'd0);

    // Back-to-back frames at full output rate
    words[0] = 5'b11001; words[1] = 5'b00000; words[2] = 5'b11111; words[3] = 5'b01010;
    n_acc = 0; valid_cycles = 0;
    s_tvalid = 1'b1; s_tdata = words[0]; m_tready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      #1;
      acc = s_tvalid && s_tready;
      if (acc && c > 0) chk("b2b_accept_on_last", 32'(m_tlast), 32'd1);
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 4) s_tvalid = 1'b0;
        else s_tdata = words[n_acc];
      end
      if (m_tvalid) valid_cycles++;
    end
    chk("b2b_words", n_acc, 32'd4);
    chk("b2b_duty", valid_cycles, 32'd20);

    // Counter source with random input stalls and output blocking
    beats_seen = 0; cnt = 0;
    s_tdata = '0; s_tvalid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!s_tvalid) s_tvalid = ($urandom_range(0, 4) == 0);
      m_tready = ($urandom_range(0, 4) != 0);
      #1;
      acc = s_tvalid && s_tready;
      tick();
      if (acc) begin
        cnt++;
        s_tdata  = 5'(cnt);
        s_tvalid = 1'b0;
      end
    end
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (8) tick();
    chk("ctr_queue_empty", exp_q.size(), 32'd0);
    chk("ctr_beat_count", beats_seen, 5 * cnt);

    // Mid-frame reset after three beats, then restart at mic 0
    s_tvalid = 1'b1; s_tdata = 5'b01101; m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(m_tvalid), 32'd0);
    chk("midrst_last", 32'(m_tlast), 32'd0);
    chk("midrst_data", 32'(m_tdata), 32'd0);
    chk("midrst_in_ready", 32'(s_tready), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    frame_directed("after_rst", 5'b10011, 40'h01FFFF0101);
    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
